exmem_pipe_reg: RTL and testbench

Parametrised EX/MEM pipeline register for the RISC-V core with a valid/ready handshake, flush (bubble) insertion and registered memory-address and byte-lane generation. It sits between the EX stage (ALU, forwarding muxes) and the data-memory/MEM stage. It replaces the fixed 32-bit EX/MEM latch with backpressure-aware single-entry buffering.

---
 rtl/exmem_pipe_reg.sv | 172 +++++++++++++++++
 tb/tb_exmem_pipe_reg.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register: valid/ready single-entry buffer with flush, registered
// effective address, lane-replicated store data and byte enables. Define EXMEM_MISALIGN_EN to add misalign_o.
module exmem_pipe_reg #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         WB_i,
  input  logic [1:0]         Mem_i,
  input  logic [1:0]         size_i,
  input  logic [XLEN-1:0]    ALUres_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [1:0]         WB_o,
  output logic [1:0]         Mem_o,
  output logic [1:0]         size_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]    ALUres_o,
  output logic [XLEN-1:0]    Memaddr_o,
  output logic [XLEN-1:0]    Memdata_o,
`ifdef EXMEM_MISALIGN_EN
  output logic               misalign_o,
`endif
  output logic [XLEN/8-1:0]  Membe_o
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(LANES);
  localparam int unsigned MW    = 2 * LANES;

  logic               valid_q, valid_d;
  logic [1:0]         wb_q, wb_d, mem_q, mem_d, size_q, size_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]    alu_q, alu_d, addr_q, addr_d, data_q, data_d;
  logic [LANES-1:0]   be_q, be_d;

  logic [XLEN-1:0]    addr_c, data_c;
  logic [OFFW-1:0]    off_c;
  logic [1:0]         size_eff_c;
  logic [3:0]         nb_c;
  logic [MW-1:0]      mask_c;
  logic [LANES-1:0]   be_c;
  logic               capture_c;

`ifdef EXMEM_MISALIGN_EN
  logic mis_q, mis_d, mis_c;
`endif

  assign ready_o   = ~valid_q | ready_i;
  assign capture_c = valid_i & ready_o & ~flush_i;

  always_comb begin
    addr_c     = rs1_data_i + ((Mem_i == 2'b01) ? rs2_data_i : imm_i);
    off_c      = addr_c[OFFW-1:0];
    size_eff_c = ((XLEN == 32) && (size_i == 2'b11)) ? 2'b10 : size_i;
    nb_c       = 4'd1 << size_eff_c;
    // Mask is built double-width so the shifted-out upper lanes truncate cleanly.
    mask_c     = (MW'(1) << nb_c) - MW'(1);
    mask_c     = mask_c << off_c;
    be_c       = (Mem_i == 2'b00) ? '0 : mask_c[LANES-1:0];
    unique case (size_eff_c)
      2'b00:   data_c = {LANES{rs2_data_i[7:0]}};
      2'b01:   data_c = {(LANES/2){rs2_data_i[15:0]}};
      2'b10:   data_c = {(LANES/4){rs2_data_i[31:0]}};
      default: data_c = rs2_data_i;
    endcase
`ifdef EXMEM_MISALIGN_EN
    mis_c = (Mem_i != 2'b00) && ((4'(off_c) & (nb_c - 4'd1)) != 4'd0);
`endif
  end

  always_comb begin
    valid_d = valid_q;
    wb_d    = wb_q;
    mem_d   = mem_q;
    size_d  = size_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
`ifdef EXMEM_MISALIGN_EN
    mis_d   = mis_q;
`endif
    if (flush_i) begin
      valid_d = 1'b0;
      wb_d    = '0;
      mem_d   = '0;
`ifdef EXMEM_MISALIGN_EN
      mis_d   = 1'b0;
`endif
    end else if (capture_c) begin
      valid_d = 1'b1;
      wb_d    = WB_i;
      mem_d   = Mem_i;
      size_d  = size_i;
      rd_d    = rd_addr_i;
      alu_d   = ALUres_i;
      addr_d  = addr_c;
      data_d  = data_c;
      be_d    = be_c;
`ifdef EXMEM_MISALIGN_EN
      // Misaligned access stays valid for the trap logic but is stripped of side effects.
      mis_d   = mis_c;
      if (mis_c) begin
        mem_d   = '0;
        be_d    = '0;
        wb_d[1] = 1'b0;
      end
`endif
    end else if (ready_i) begin
      valid_d = 1'b0;
      wb_d    = '0;
      mem_d   = '0;
`ifdef EXMEM_MISALIGN_EN
      mis_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      wb_q    <= '0;
      mem_q   <= '0;
      size_q  <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
`ifdef EXMEM_MISALIGN_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      mem_q   <= mem_d;
      size_q  <= size_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
`ifdef EXMEM_MISALIGN_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign valid_o   = valid_q;
  assign WB_o      = wb_q;
  assign Mem_o     = mem_q;
  assign size_o    = size_q;
  assign rd_addr_o = rd_q;
  assign ALUres_o  = alu_q;
  assign Memaddr_o = addr_q;
  assign Memdata_o = data_q;
  assign Membe_o   = be_q;
`ifdef EXMEM_MISALIGN_EN
  assign misalign_o = mis_q;
`endif

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Bench for exmem_pipe_reg (XLEN=32): directed scenarios plus randomized traffic against a reference model.
module tb_exmem_pipe_reg;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic        ready_o, valid_o;
  logic [1:0]  WB_i = '0, Mem_i = '0, size_i = '0;
  logic [31:0] ALUres_i = '0, rs1_data_i = '0, rs2_data_i = '0, imm_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic [1:0]  WB_o, Mem_o, size_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] ALUres_o, Memaddr_o, Memdata_o;
  logic [3:0]  Membe_o;
`ifdef EXMEM_MISALIGN_EN
  logic        misalign_o;
  logic        e_mis;
`endif

  int errors = 0;
  int checks = 0;

  logic        e_valid;
  logic [1:0]  e_wb, e_mem, e_size;
  logic [4:0]  e_rd;
  logic [31:0] e_alu, e_addr, e_data;
  logic [3:0]  e_be;
  bit          e_dc;

  exmem_pipe_reg #(.XLEN(32), .RADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .WB_i(WB_i), .Mem_i(Mem_i), .size_i(size_i), .ALUres_i(ALUres_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rd_addr_i(rd_addr_i),
    .valid_o(valid_o), .ready_i(ready_i), .WB_o(WB_o), .Mem_o(Mem_o), .size_o(size_o),
    .rd_addr_o(rd_addr_o), .ALUres_o(ALUres_o), .Memaddr_o(Memaddr_o), .Memdata_o(Memdata_o),
`ifdef EXMEM_MISALIGN_EN
    .misalign_o(misalign_o),
`endif
    .Membe_o(Membe_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit (errors=%0d)", errors);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    e_valid = 0; e_wb = 0; e_mem = 0; e_size = 0; e_rd = 0;
    e_alu = 0; e_addr = 0; e_data = 0; e_be = 0; e_dc = 0;
`ifdef EXMEM_MISALIGN_EN
    e_mis = 0;
`endif
  endtask

  // Reference behaviour for one edge, then advance to just after that edge.
  task automatic tick();
    logic [31:0] a;
    int nb, off;
    if (flush_i) begin
      e_valid = 0; e_wb = 0; e_mem = 0; e_dc = 1;
`ifdef EXMEM_MISALIGN_EN
      e_mis = 0;
`endif
    end else if (valid_i && (!e_valid || ready_i)) begin
      a   = rs1_data_i + ((Mem_i == 2'd1) ? rs2_data_i : imm_i);
      nb  = (size_i == 2'd0) ? 1 : (size_i == 2'd1) ? 2 : 4;
      off = int'(a % 4);
      e_valid = 1; e_wb = WB_i; e_mem = Mem_i; e_size = size_i; e_rd = rd_addr_i;
      e_alu = ALUres_i; e_addr = a; e_dc = 0;
      e_be = (Mem_i == 2'd0) ? 4'd0 : 4'((((1 << nb) - 1) << off) & 15);
      case (nb)
        1:       e_data = {24'd0, rs2_data_i[7:0]} * 32'h0101_0101;
        2:       e_data = {16'd0, rs2_data_i[15:0]} * 32'h0001_0001;
        default: e_data = rs2_data_i;
      endcase
`ifdef EXMEM_MISALIGN_EN
      e_mis = (Mem_i != 2'd0) && ((off % nb) != 0);
      if (e_mis) begin e_mem = 0; e_be = 0; e_wb[1] = 1'b0; end
`endif
    end else if (ready_i) begin
      e_valid = 0; e_wb = 0; e_mem = 0;
`ifdef EXMEM_MISALIGN_EN
      e_mis = 0;
`endif
    end
    @(posedge clk_i); #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] mem,
                       input logic [1:0] sz, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm);
    valid_i = v; WB_i = wb; Mem_i = mem; size_i = sz;
    rs1_data_i = rs1; rs2_data_i = rs2; imm_i = imm;
    ALUres_i = $urandom; rd_addr_i = 5'($urandom);
  endtask

  task automatic test_reset();
    rst_i = 0; ready_i = 1;
    drive(1, 2'b11, 2'b10, 2'b10, 32'h1000, 32'h0, 32'h10);
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({valid_o, WB_o, Mem_o, size_o, rd_addr_o, ALUres_o, Memaddr_o, Memdata_o, Membe_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b WB=%b Mem=%b addr=%h data=%h be=%b required all 0",
               valid_o, WB_o, Mem_o, Memaddr_o, Memdata_o, Membe_o);
    end
    valid_i = 0; rst_i = 1; model_reset();
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: ready_o=%b required 1", ready_o); end
    tick();
    drive(1, 2'b11, 2'b10, 2'b10, 32'h40, 32'h0, 32'h4);
    tick();
    valid_i = 0; ready_i = 0;
    tick();
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL hold_before_reset: valid_o=%b required 1", valid_o); end
    #2 rst_i = 0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || WB_o !== 2'b00) begin
      errors++; $display("FAIL async_reset: valid_o=%b WB_o=%b required 0 00", valid_o, WB_o);
    end
    rst_i = 1; model_reset(); ready_i = 1;
    tick();
  endtask

  task automatic test_load();
    drive(1, 2'b11, 2'b10, 2'b10, 32'h1000, 32'h0, 32'h10);
    ready_i = 1;
    tick();
    checks++;
    if (valid_o !== 1'b1 || Memaddr_o !== 32'h1010 || Membe_o !== 4'b1111 || Mem_o !== 2'b10) begin
      errors++;
      $display("FAIL load_word: valid=%b addr=%h be=%b Mem=%b required 1 00001010 1111 10",
               valid_o, Memaddr_o, Membe_o, Mem_o);
    end
  endtask

  task automatic test_indexed();
    drive(1, 2'b11, 2'b01, 2'b00, 32'h2000, 32'h3, 32'h7777);
    tick();
    checks++;
    if (Memaddr_o !== 32'h2003 || Membe_o !== 4'b1000) begin
      errors++; $display("FAIL indexed_byte: addr=%h be=%b required 00002003 1000", Memaddr_o, Membe_o);
    end
    drive(1, 2'b10, 2'b10, 2'b10, 32'hFFFF_FFFC, 32'h5, 32'h8);
    tick();
    checks++;
    if (Memaddr_o !== 32'h0000_0004 || Membe_o !== 4'b1111) begin
      errors++; $display("FAIL addr_wrap: addr=%h be=%b required 00000004 1111", Memaddr_o, Membe_o);
    end
  endtask

  task automatic test_store();
    drive(1, 2'b00, 2'b11, 2'b00, 32'h100, 32'h0000_00AB, 32'h1);
    tick();
    checks++;
    if (Memdata_o !== 32'hABAB_ABAB || Membe_o !== 4'b0010 || Memaddr_o !== 32'h101) begin
      errors++;
      $display("FAIL store_byte: data=%h be=%b addr=%h required ABABABAB 0010 00000101",
               Memdata_o, Membe_o, Memaddr_o);
    end
    drive(1, 2'b00, 2'b11, 2'b01, 32'h200, 32'h1234_BEEF, 32'h2);
    tick();
    checks++;
    if (Memdata_o !== 32'hBEEF_BEEF || Membe_o !== 4'b1100) begin
      errors++; $display("FAIL store_half: data=%h be=%b required BEEFBEEF 1100", Memdata_o, Membe_o);
    end
  endtask

  task automatic test_backpressure();
    drive(1, 2'b11, 2'b10, 2'b10, 32'h3000, 32'h0, 32'h8);
    ready_i = 1;
    tick();
    drive(1, 2'b11, 2'b10, 2'b10, 32'h5000, 32'h0, 32'h20);
    ready_i = 0;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low: ready_o=%b required 0", ready_o); end
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (valid_o !== 1'b1 || Memaddr_o !== 32'h3008) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b addr=%h required 1 00003008", k, valid_o, Memaddr_o);
      end
    end
    ready_i = 1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_high: ready_o=%b required 1", ready_o); end
    tick();
    checks++;
    if (valid_o !== 1'b1 || Memaddr_o !== 32'h5020) begin
      errors++; $display("FAIL bp_release: valid=%b addr=%h required 1 00005020", valid_o, Memaddr_o);
    end
    valid_i = 0;
    tick();
    checks++;
    if (valid_o !== 1'b0 || WB_o !== 2'b00 || Mem_o !== 2'b00 || Memaddr_o !== 32'h5020) begin
      errors++;
      $display("FAIL drain: valid=%b WB=%b Mem=%b addr=%h required 0 00 00 00005020",
               valid_o, WB_o, Mem_o, Memaddr_o);
    end
  endtask

  task automatic test_flush();
    drive(1, 2'b11, 2'b11, 2'b10, 32'h600, 32'h1, 32'h0);
    ready_i = 1;
    tick();
    drive(1, 2'b11, 2'b10, 2'b10, 32'h700, 32'h1, 32'h0);
    flush_i = 1;
    tick();
    checks++;
    if (valid_o !== 1'b0 || WB_o !== 2'b00 || Mem_o !== 2'b00) begin
      errors++; $display("FAIL flush_capture: valid=%b WB=%b Mem=%b required 0 00 00", valid_o, WB_o, Mem_o);
    end
    flush_i = 0;
    tick();
    valid_i = 0; ready_i = 0;
    tick();
    flush_i = 1;
    tick();
    checks++;
    if (valid_o !== 1'b0 || WB_o !== 2'b00 || Mem_o !== 2'b00) begin
      errors++; $display("FAIL flush_hold: valid=%b WB=%b Mem=%b required 0 00 00", valid_o, WB_o, Mem_o);
    end
    flush_i = 0; ready_i = 1;
    tick();
  endtask

`ifdef EXMEM_MISALIGN_EN
  task automatic test_misalign();
    drive(1, 2'b10, 2'b11, 2'b01, 32'h100, 32'h55AA, 32'h1);
    ready_i = 1;
    tick();
    checks++;
    if (misalign_o !== 1'b1 || Membe_o !== 4'b0000 || Mem_o !== 2'b00 || valid_o !== 1'b1 || WB_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL misalign_set: mis=%b be=%b Mem=%b valid=%b WB=%b required 1 0000 00 1 0x",
               misalign_o, Membe_o, Mem_o, valid_o, WB_o);
    end
    valid_i = 0;
    tick();
    checks++;
    if (misalign_o !== 1'b0) begin errors++; $display("FAIL misalign_clear: mis=%b required 0", misalign_o); end
  endtask
`endif

  task automatic test_random();
    for (int unsigned n = 0; n < 500; n++) begin
      flush_i = ($urandom_range(0, 9) == 0);
      ready_i = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, 2'($urandom), 2'($urandom), 2'($urandom),
            $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : $urandom,
            ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : $urandom);
      #1;
      checks++;
      if (ready_o !== (!e_valid || ready_i)) begin
        errors++; $display("FAIL rand_ready[%0d]: ready_o=%b required %b", n, ready_o, !e_valid || ready_i);
      end
      tick();
      checks++;
      if (e_dc) begin
        if ({valid_o, WB_o, Mem_o} !== {e_valid, e_wb, e_mem}) begin
          errors++;
          $display("FAIL rand_ctrl[%0d]: valid=%b WB=%b Mem=%b required %b %b %b",
                   n, valid_o, WB_o, Mem_o, e_valid, e_wb, e_mem);
        end
      end else if ({valid_o, WB_o, Mem_o, size_o, rd_addr_o, ALUres_o, Memaddr_o, Memdata_o, Membe_o} !==
                   {e_valid, e_wb, e_mem, e_size, e_rd, e_alu, e_addr, e_data, e_be}) begin
        errors++;
        $display("FAIL rand_all[%0d]: got v=%b wb=%b mem=%b sz=%b rd=%h alu=%h addr=%h data=%h be=%b required v=%b wb=%b mem=%b sz=%b rd=%h alu=%h addr=%h data=%h be=%b",
                 n, valid_o, WB_o, Mem_o, size_o, rd_addr_o, ALUres_o, Memaddr_o, Memdata_o, Membe_o,
                 e_valid, e_wb, e_mem, e_size, e_rd, e_alu, e_addr, e_data, e_be);
      end
`ifdef EXMEM_MISALIGN_EN
      checks++;
      if (misalign_o !== e_mis) begin
        errors++; $display("FAIL rand_mis[%0d]: mis=%b required %b", n, misalign_o, e_mis);
      end
`endif
    end
    flush_i = 0; valid_i = 0; ready_i = 1;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_indexed();
    test_store();
    test_backpressure();
    test_flush();
`ifdef EXMEM_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
